pipelined_array_multiplier: RTL and testbench
=============================================

PIPELINED_ARRAY_MULTIPLIER -- requirements
Module: pipelined_array_multiplier

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 SHALL have parameter NUM_PIPELINE_STAGES, default 2, register stages from operand acceptance to result (legal 1..DATAWIDTH).
REQ-003 SHALL have parameter INSTANCE_ID, default 0, identification tag only; no functional effect.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_valid  input  1  operands A/B/i_signed valid this cycle.
REQ-007 SHALL have port i_ready  output  1  block accepts operands this cycle.
REQ-008 SHALL have port A  input  DATAWIDTH  multiplicand.
REQ-009 SHALL have port B  input  DATAWIDTH  multiplier.
REQ-010 SHALL have port i_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-011 SHALL have port o_valid  output  1  Z_final holds a valid product.
REQ-012 SHALL have port o_ready  input  1  downstream accepts Z_final this cycle.
REQ-013 SHALL have port Z_final  output  2*DATAWIDTH  product.
REQ-014 SHALL have port o_busy  output  1  at least one stage holds a valid entry.

Function
REQ-015 SHALL compute the full 2*DATAWIDTH-bit product; no truncation or saturation.
REQ-016 SHALL, with i_signed=1, produce the two's-complement product (Baugh-Wooley row correction); with i_signed=0, the unsigned product.
REQ-017 SHALL carry i_signed with its operands through the pipeline so mixed-mode back-to-back operations are each correct.
REQ-018 SHALL split DATAWIDTH partial-product rows into NUM_PIPELINE_STAGES groups; stage k (1-based) ends after row floor(k*DATAWIDTH/NUM_PIPELINE_STAGES); last stage registers Z_final.
REQ-019 SHALL keep one valid bit per stage; the last stage's valid bit drives o_valid.
REQ-020 SHALL define advance = !o_valid || o_ready; every stage loads from its predecessor when advance=1 and holds all contents when advance=0.
REQ-021 SHALL drive i_ready = advance && !rst; an operand is accepted when i_valid && i_ready.
REQ-022 SHALL load a 0 valid bit into stage 1 when advance=1 and no operand is accepted (bubble).
REQ-023 SHALL, with o_ready held 1, present the result exactly NUM_PIPELINE_STAGES cycles after acceptance, sustaining one result per cycle.
REQ-024 SHALL hold Z_final and o_valid stable while o_valid=1 and o_ready=0.
REQ-025 SHALL drive o_busy as the OR of all stage valid bits.

Reset
REQ-026 SHALL clear all stage valid bits, o_valid=0, o_busy=0, Z_final=0 on the first clock edge with rst=1.
REQ-027 SHALL discard all in-flight operations when rst is asserted mid-operation; no result from before reset appears afterwards.
REQ-028 SHALL ignore i_valid while rst=1 (i_ready=0) and accept operands from the first cycle after rst deasserts.

Configuration
REQ-029 SHALL honour macro ARRAY_MUL_SIGNED_EN: defined -> REQ-016/REQ-017 signed support built in.
REQ-030 SHALL, when ARRAY_MUL_SIGNED_EN is undefined, keep port i_signed but ignore it; all operations unsigned and no correction logic or signed pipeline bit synthesised.

Verification (DATAWIDTH=4, NUM_PIPELINE_STAGES=2, macro defined unless noted)
REQ-031 SHALL cover: A=15, B=15, i_signed=0, o_ready=1 -> Z_final=0xE1, o_valid high exactly 2 cycles after acceptance.
REQ-032 SHALL cover: A=0x8, B=0x8, i_signed=1 -> Z_final=0x40; then A=0x8, B=0x7, i_signed=1 -> Z_final=0xC8 on the next cycle.
REQ-033 SHALL cover: 4 back-to-back operations (3*5, 0*9, 15*1, 7*7), o_ready=1 -> results 0x0F, 0x00, 0x0F, 0x31 on 4 consecutive cycles, in order.
REQ-034 SHALL cover: o_ready=0 for 5 cycles with 2 results in flight -> o_valid/Z_final held, i_ready=0, no loss; o_ready=1 -> both drain in order.
REQ-035 SHALL cover: rst=1 one cycle after accepting 6*6 -> o_valid and o_busy stay 0, Z_final=0, 0x24 never appears.
REQ-036 SHALL cover, macro undefined: A=0x8, B=0x8, i_signed=1 -> Z_final=0x40; A=0x8, B=0x7, i_signed=1 -> Z_final=0x38.

Source files
------------

// File: rtl/pipelined_array_multiplier.sv
// Pipelined array multiplier: DATAWIDTH partial-product rows summed across NUM_PIPELINE_STAGES
// register stages. Define ARRAY_MUL_SIGNED_EN to build in Baugh-Wooley signed support.
module pipelined_array_multiplier #(
   parameter int DATAWIDTH           = 8,
   parameter int NUM_PIPELINE_STAGES = 2,
   parameter int INSTANCE_ID         = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_valid,
   output logic                   i_ready,
   input  logic [DATAWIDTH-1:0]   A,
   input  logic [DATAWIDTH-1:0]   B,
   input  logic                   i_signed,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic [2*DATAWIDTH-1:0] Z_final,
   output logic                   o_busy
);
   localparam int STAGES = NUM_PIPELINE_STAGES;
   localparam int PW     = 2 * DATAWIDTH;

   logic                           advance;
   logic                           accept;
   logic [STAGES:1]                vld_all;
   logic [STAGES:1][DATAWIDTH-1:0] a_all;
   logic [STAGES:1][DATAWIDTH-1:0] b_all;
   logic [STAGES:1][PW-1:0]        acc_all;
   logic [31:0]                    unused_id;
   logic                           unused_tail;

   assign unused_id = INSTANCE_ID;

`ifdef ARRAY_MUL_SIGNED_EN
   // Inverting the sign-bit cross terms leaves this constant to add back (mod 2^PW).
   localparam logic [PW-1:0] BW_CORR = (PW'(1) << DATAWIDTH) | (PW'(1) << (PW - 1));

   logic [STAGES:1] sgn_all;

   function automatic logic [PW-1:0] pp_row(input logic [DATAWIDTH-1:0] a,
                                            input logic [DATAWIDTH-1:0] b,
                                            input int                   row,
                                            input logic                 sgn);
      logic                 bbit;
      logic [DATAWIDTH-1:0] bits;
      bbit = |(b & (DATAWIDTH'(1) << row));
      bits = a & {DATAWIDTH{bbit}};
      if (sgn) begin
         if (row == DATAWIDTH - 1) bits[DATAWIDTH-2:0] = ~bits[DATAWIDTH-2:0];
         else                      bits[DATAWIDTH-1]   = ~bits[DATAWIDTH-1];
      end
      return {{DATAWIDTH{1'b0}}, bits} << row;
   endfunction

   assign unused_tail = ^{a_all[STAGES], b_all[STAGES], sgn_all[STAGES]};
`else
   logic unused_signed;

   function automatic logic [PW-1:0] pp_row(input logic [DATAWIDTH-1:0] a,
                                            input logic [DATAWIDTH-1:0] b,
                                            input int                   row);
      logic                 bbit;
      logic [DATAWIDTH-1:0] bits;
      bbit = |(b & (DATAWIDTH'(1) << row));
      bits = a & {DATAWIDTH{bbit}};
      return {{DATAWIDTH{1'b0}}, bits} << row;
   endfunction

   assign unused_signed = i_signed;
   assign unused_tail   = ^{a_all[STAGES], b_all[STAGES]};
`endif

   assign advance = !vld_all[STAGES] || o_ready;
   assign i_ready = advance && !rst;
   assign accept  = i_valid && i_ready;
   assign o_valid = vld_all[STAGES];
   assign o_busy  = |vld_all;
   assign Z_final = acc_all[STAGES];

   for (genvar k = 1; k <= STAGES; k++) begin : g_stage
      // Stage k adds rows [ROW_LO, ROW_HI) onto the accumulator handed over by stage k-1.
      localparam int ROW_LO = ((k - 1) * DATAWIDTH) / STAGES;
      localparam int ROW_HI = (k * DATAWIDTH) / STAGES;

      logic [DATAWIDTH-1:0] src_a, src_b, a_p, b_p;
      logic [PW-1:0]        src_acc, nxt_acc, acc_p;
      logic                 ld, vld_p;
`ifdef ARRAY_MUL_SIGNED_EN
      logic                 src_sgn, sgn_p;
`endif

      if (k == 1) begin : g_src
         assign src_a   = A;
         assign src_b   = B;
         assign ld      = accept;
`ifdef ARRAY_MUL_SIGNED_EN
         assign src_sgn = i_signed;
         assign src_acc = i_signed ? BW_CORR : '0;
`else
         assign src_acc = '0;
`endif
      end else begin : g_src
         assign src_a   = a_all[k-1];
         assign src_b   = b_all[k-1];
         assign ld      = vld_all[k-1];
         assign src_acc = acc_all[k-1];
`ifdef ARRAY_MUL_SIGNED_EN
         assign src_sgn = sgn_all[k-1];
`endif
      end

      always_comb begin
         nxt_acc = src_acc;
         for (int r = ROW_LO; r < ROW_HI; r++) begin
`ifdef ARRAY_MUL_SIGNED_EN
            nxt_acc = nxt_acc + pp_row(src_a, src_b, r, src_sgn);
`else
            nxt_acc = nxt_acc + pp_row(src_a, src_b, r);
`endif
         end
      end

      // Data moves only with a valid entry so a flushed operation can never reach Z_final.
      always_ff @(posedge clk) begin
         if (advance && ld) begin
            a_p   <= src_a;
            b_p   <= src_b;
            acc_p <= nxt_acc;
`ifdef ARRAY_MUL_SIGNED_EN
            sgn_p <= src_sgn;
`endif
         end
         if (rst) begin
            vld_p <= 1'b0;
            if (k == STAGES) acc_p <= '0;
         end else if (advance) begin
            vld_p <= ld;
         end
      end

      assign vld_all[k] = vld_p;
      assign a_all[k]   = a_p;
      assign b_all[k]   = b_p;
      assign acc_all[k] = acc_p;
`ifdef ARRAY_MUL_SIGNED_EN
      assign sgn_all[k] = sgn_p;
`endif
   end

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Self-checking bench for pipelined_array_multiplier at DATAWIDTH=4, two stages: directed table,
// back-to-back / stall / reset sequences, and randomized traffic against a reference model.
module tb_pipelined_array_multiplier;
   localparam int W = 4;
`ifdef ARRAY_MUL_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic           clk;
   logic           rst;
   logic           i_valid;
   logic           i_ready;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic           i_signed;
   logic           o_valid;
   logic           o_ready;
   logic [2*W-1:0] Z_final;
   logic           o_busy;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q [$];
   logic [7:0] sb_exp;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       s;
      logic [7:0] exp_s;
      logic [7:0] exp_u;
   } vec_t;

   vec_t       vecs [13];
   logic [3:0] b2b_a [6];
   logic [3:0] b2b_b [6];
   logic       b2b_s [6];
   logic [7:0] b2b_z [6];

   pipelined_array_multiplier #(
      .DATAWIDTH          (W),
      .NUM_PIPELINE_STAGES(2),
      .INSTANCE_ID        (0)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .A       (A),
      .B       (B),
      .i_signed(i_signed),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .Z_final (Z_final),
      .o_busy  (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ref_product(input logic [3:0] a, input logic [3:0] b,
                                              input logic s);
      int x;
      int y;
      x = int'(a);
      y = int'(b);
      if (s && SIGNED_EN) begin
         if (x >= 8) x = x - 16;
         if (y >= 8) y = y - 16;
      end
      return 8'(x * y);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every accepted operand pair must come out once, in order, with the right product.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (o_valid && o_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_spurious: actual result 0x%0h, required no result", Z_final);
            end else begin
               sb_exp = exp_q.pop_front();
               if (Z_final !== sb_exp) begin
                  n_fail++;
                  $display("FAIL sb_product: actual 0x%0h, required 0x%0h", Z_final, sb_exp);
               end
            end
         end
         if (i_valid && i_ready) exp_q.push_back(ref_product(A, B, i_signed));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the end of the test");
      $fatal(1);
   end

   initial begin
      int lat;
      rst = 1'b1; i_valid = 1'b0; A = '0; B = '0; i_signed = 1'b0; o_ready = 1'b1;

      vecs[0]  = '{4'hF, 4'hF, 1'b0, 8'hE1, 8'hE1};
      vecs[1]  = '{4'h8, 4'h8, 1'b1, 8'h40, 8'h40};
      vecs[2]  = '{4'h8, 4'h7, 1'b1, 8'hC8, 8'h38};
      vecs[3]  = '{4'h3, 4'h5, 1'b0, 8'h0F, 8'h0F};
      vecs[4]  = '{4'h0, 4'h9, 1'b0, 8'h00, 8'h00};
      vecs[5]  = '{4'hF, 4'h1, 1'b0, 8'h0F, 8'h0F};
      vecs[6]  = '{4'h7, 4'h7, 1'b0, 8'h31, 8'h31};
      vecs[7]  = '{4'hF, 4'hF, 1'b1, 8'h01, 8'hE1};
      vecs[8]  = '{4'hF, 4'h1, 1'b1, 8'hFF, 8'h0F};
      vecs[9]  = '{4'h8, 4'h1, 1'b1, 8'hF8, 8'h08};
      vecs[10] = '{4'h7, 4'h7, 1'b1, 8'h31, 8'h31};
      vecs[11] = '{4'h0, 4'h8, 1'b1, 8'h00, 8'h00};
      vecs[12] = '{4'h9, 4'h6, 1'b1, 8'hD6, 8'h36};

      b2b_a = '{4'd3, 4'd0, 4'd15, 4'd7, 4'h8, 4'h8};
      b2b_b = '{4'd5, 4'd9, 4'd1,  4'd7, 4'h8, 4'h7};
      b2b_s = '{1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b1};
      b2b_z = '{8'h0F, 8'h00, 8'h0F, 8'h31, 8'h40, (SIGNED_EN ? 8'hC8 : 8'h38)};

      // Reset state
      tick();
      tick();
      @(negedge clk);
      check("rst_o_valid", o_valid, 0);
      check("rst_o_busy", o_busy, 0);
      check("rst_z_final", Z_final, 0);
      check("rst_i_ready", i_ready, 0);
      tick();
      rst = 1'b0;

      // Directed table: single operations, latency and product
      for (int i = 0; i < 13; i++) begin
         i_valid = 1'b1; A = vecs[i].a; B = vecs[i].b; i_signed = vecs[i].s;
         @(negedge clk);
         check("tbl_i_ready", i_ready, 1);
         tick();
         i_valid = 1'b0;
         lat = 0;
         while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (o_valid) break;
         end
         check("tbl_latency", lat, 2);
         check("tbl_product", Z_final, (vecs[i].s && SIGNED_EN) ? vecs[i].exp_s : vecs[i].exp_u);
         tick();
      end

      // Back-to-back, mixed signed/unsigned, one result per cycle in order
      for (int c = 0; c < 9; c++) begin
         if (c < 6) begin
            i_valid = 1'b1; A = b2b_a[c]; B = b2b_b[c]; i_signed = b2b_s[c];
         end else begin
            i_valid = 1'b0;
         end
         @(negedge clk);
         if (c >= 2 && c <= 7) begin
            check("b2b_o_valid", o_valid, 1);
            check("b2b_product", Z_final, b2b_z[c-2]);
         end else begin
            check("b2b_o_valid_idle", o_valid, 0);
         end
         tick();
      end

      // Output stall with two results in flight
      o_ready = 1'b0;
      i_valid = 1'b1; A = 4'd9; B = 4'd9; i_signed = 1'b0;
      @(negedge clk);
      check("stall_accept0", i_ready, 1);
      tick();
      A = 4'd2; B = 4'd13;
      @(negedge clk);
      check("stall_accept1", i_ready, 1);
      tick();
      i_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_o_valid", o_valid, 1);
         check("stall_hold_z", Z_final, 8'h51);
         check("stall_i_ready", i_ready, 0);
         check("stall_o_busy", o_busy, 1);
         tick();
      end
      o_ready = 1'b1;
      @(negedge clk);
      check("drain_first_valid", o_valid, 1);
      check("drain_first_z", Z_final, 8'h51);
      tick();
      @(negedge clk);
      check("drain_second_valid", o_valid, 1);
      check("drain_second_z", Z_final, 8'h1A);
      tick();
      @(negedge clk);
      check("drain_empty_valid", o_valid, 0);
      check("drain_empty_busy", o_busy, 0);
      tick();

      // Reset one cycle after accepting 6*6
      i_valid = 1'b1; A = 4'd6; B = 4'd6; i_signed = 1'b0;
      @(negedge clk);
      check("flush_accept", i_ready, 1);
      tick();
      rst = 1'b1; A = 4'd5; B = 4'd5;
      @(negedge clk);
      check("flush_ready_in_rst", i_ready, 0);
      tick();
      rst = 1'b0; i_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 0) check("flush_ready_after_rst", i_ready, 1);
         check("flush_o_valid", o_valid, 0);
         check("flush_o_busy", o_busy, 0);
         check("flush_z_final", Z_final, 0);
         tick();
      end

      // Randomized traffic with random backpressure
      for (int c = 0; c < 400; c++) begin
         i_valid  = ($urandom_range(0, 9) < 7);
         A        = 4'($urandom_range(0, 15));
         B        = 4'($urandom_range(0, 15));
         i_signed = 1'($urandom_range(0, 1));
         o_ready  = ($urandom_range(0, 9) < 7);
         tick();
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!o_busy) break;
         tick();
      end
      check("rand_drain_busy", o_busy, 0);
      check("rand_drain_queue", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
